// File: rtl/cic_pkg.sv
// Shared definitions for the multi-channel CIC decimator: control states,
// width derivation and the ratio-dependent gain-normalisation shift.
package cic_pkg;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } ctl_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Full gain is d^n; fractional output LSBs (ow > iw) reduce the shift, floored at 0.
  function automatic int unsigned shift_amt(input int unsigned d, input int unsigned n,
                                            input int unsigned iw, input int unsigned ow);
    int unsigned s;
    int unsigned frac;
    s    = n * clog2(d);
    frac = (ow > iw) ? ow - iw : 0;
    return (s > frac) ? s - frac : 0;
  endfunction

  function automatic int unsigned regwidth(input int unsigned iw, input int unsigned n,
                                           input int unsigned max_d);
    return iw + n * clog2(max_d);
  endfunction

endpackage

// File: rtl/cic_lane.sv
// One CIC channel: N wrapping integrators, N-stage strobe-advanced comb and
// gain normalisation (truncate, or round-half-up with saturation).
module cic_lane
  import cic_pkg::*;
#(
  parameter int INPUTWIDTH  = 8,
  parameter int OUTPUTWIDTH = 8,
  parameter int N           = 4,
  parameter int REGWIDTH    = 24,
  parameter int ROUND       = 0,
  parameter int SHW         = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          dec_stb,
  input  logic signed [INPUTWIDTH-1:0]  d_in,
  input  logic        [SHW-1:0]         shift,
  output logic signed [OUTPUTWIDTH-1:0] d_out,
  output logic                          out_valid
);

  localparam logic signed [REGWIDTH:0] OMAX =
    {{(REGWIDTH-OUTPUTWIDTH+2){1'b0}}, {(OUTPUTWIDTH-1){1'b1}}};
  localparam logic signed [REGWIDTH:0] OMIN = ~OMAX;

  logic signed [REGWIDTH-1:0]    integ [N];
  logic signed [REGWIDTH-1:0]    comb  [N];
  logic signed [REGWIDTH-1:0]    dly   [N];
  logic        [SHW-1:0]         sh    [N];
  logic        [N-1:0]           v;
  logic signed [REGWIDTH:0]      ext, half, biased, shifted;
  logic signed [OUTPUTWIDTH-1:0] norm;

  always_comb begin
    ext     = {comb[N-1][REGWIDTH-1], comb[N-1]};
    half    = {{REGWIDTH{1'b0}}, 1'b1} << sh[N-1];
    half    = half >> 1;
    biased  = (ROUND != 0) ? ext + half : ext;
    shifted = biased >>> sh[N-1];
    norm    = shifted[OUTPUTWIDTH-1:0];
    if (ROUND != 0) begin
      if (shifted > OMAX)      norm = OMAX[OUTPUTWIDTH-1:0];
      else if (shifted < OMIN) norm = OMIN[OUTPUTWIDTH-1:0];
    end
  end

  // The shift amount travels with its frame so a ratio change never re-scales data in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < N; s++) begin
        integ[s] <= '0;
        comb[s]  <= '0;
        dly[s]   <= '0;
        sh[s]    <= '0;
      end
      v         <= '0;
      out_valid <= 1'b0;
      d_out     <= '0;
    end else begin
      if (in_valid) begin
        integ[0] <= integ[0] + REGWIDTH'(d_in);
        for (int unsigned s = 1; s < N; s++) integ[s] <= integ[s] + integ[s-1];
      end
      v[0] <= dec_stb;
      for (int unsigned s = 1; s < N; s++) v[s] <= v[s-1];
      if (dec_stb) begin
        comb[0] <= integ[N-1] - dly[0];
        dly[0]  <= integ[N-1];
        sh[0]   <= shift;
      end
      for (int unsigned s = 1; s < N; s++) begin
        if (v[s-1]) begin
          comb[s] <= comb[s-1] - dly[s];
          dly[s]  <= comb[s-1];
          sh[s]   <= sh[s-1];
        end
      end
      out_valid <= v[N-1];
      if (v[N-1]) d_out <= norm;
    end
  end

endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator top: shared sample counter, frame-boundary ratio
// control with sticky configuration error, and one cic_lane per channel.
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int INPUTWIDTH  = 8,
  parameter int OUTPUTWIDTH = 8,
  parameter int N           = 4,
  parameter int MAX_D       = 16,
  parameter int CHANNELS    = 2,
  parameter int ROUND       = 0,
  parameter int REGWIDTH    = regwidth(INPUTWIDTH, N, MAX_D)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [CHANNELS*INPUTWIDTH-1:0]  d_in,
  input  logic [$clog2(MAX_D):0]          D,
  output logic [CHANNELS*OUTPUTWIDTH-1:0] d_out,
  output logic                            out_valid,
  output logic                            cfg_err,
  output logic [$clog2(MAX_D):0]          d_active
);

  localparam int DW  = $clog2(MAX_D) + 1;
  localparam int CW  = $clog2(MAX_D);
  localparam int SHW = $clog2(REGWIDTH + 1);

  ctl_state_t        state;
  logic [CW-1:0]     cnt;
  logic              dec_stb;
  logic              d_legal;
  logic [SHW-1:0]    shift_now;
  logic [CHANNELS-1:0] lane_valid;

  always_comb begin
    dec_stb   = in_valid && (DW'(cnt) == d_active - DW'(1));
    d_legal   = is_pow2(32'(D)) && (D >= DW'(2)) && (D <= DW'(MAX_D));
    shift_now = SHW'(shift_amt(32'(d_active), N, INPUTWIDTH, OUTPUTWIDTH));
    out_valid = &lane_valid;
  end

  // Until the first valid sample the counter sits at 0, so D is tracked every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_PRIME;
      cnt      <= '0;
      d_active <= DW'(MAX_D);
      cfg_err  <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt   <= dec_stb ? '0 : cnt + 1'b1;
        state <= ST_RUN;
      end
      if (state == ST_PRIME || dec_stb) begin
        if (d_legal) d_active <= D;
        else         cfg_err  <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    cic_lane #(
      .INPUTWIDTH (INPUTWIDTH),
      .OUTPUTWIDTH(OUTPUTWIDTH),
      .N          (N),
      .REGWIDTH   (REGWIDTH),
      .ROUND      (ROUND),
      .SHW        (SHW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .dec_stb  (dec_stb),
      .d_in     (d_in[k*INPUTWIDTH +: INPUTWIDTH]),
      .shift    (shift_now),
      .d_out    (d_out[k*OUTPUTWIDTH +: OUTPUTWIDTH]),
      .out_valid(lane_valid[k])
    );
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: truncating and rounding instances share stimulus; a
// convolution reference model feeds a scoreboard checked by a separate monitor.
module tb_cic_decim_mc;

  localparam int IW = 8, OW = 8, N = 4, MAX_D = 16, CH = 2, DW = 5;
  localparam int HL = N * (MAX_D - 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [CH*IW-1:0] d_in = '0;
  logic [DW-1:0]    D = 5'd8;
  logic [CH*OW-1:0] d_out_t, d_out_r;
  logic ov_t, ov_r, cfg_t, cfg_r;
  logic [DW-1:0] da_t, da_r;

  always #5 clk = ~clk;

  cic_decim_mc #(.INPUTWIDTH(IW), .OUTPUTWIDTH(OW), .N(N), .MAX_D(MAX_D),
                 .CHANNELS(CH), .ROUND(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .D(D),
    .d_out(d_out_t), .out_valid(ov_t), .cfg_err(cfg_t), .d_active(da_t));

  cic_decim_mc #(.INPUTWIDTH(IW), .OUTPUTWIDTH(OW), .N(N), .MAX_D(MAX_D),
                 .CHANNELS(CH), .ROUND(1)) u_dut_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .D(D),
    .d_out(d_out_r), .out_valid(ov_r), .cfg_err(cfg_r), .d_active(da_r));

  typedef struct {
    int          due;
    bit          chk;
    logic [15:0] e_t;
    logic [15:0] e_r;
  } exp_t;

  exp_t exp_q[$];
  int   h0[$], h1[$];
  int   flen[$];
  int   m_cnt, m_dact;
  bit   m_primed, m_cfg, last_stb;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lg2(input int d);
    int r = 0;
    while ((1 << r) < d) r++;
    return r;
  endfunction

  function automatic logic [7:0] rnd(input longint y, input int sh);
    longint r;
    r = (sh > 0) ? ((y + (longint'(1) <<< (sh - 1))) >>> sh) : y;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  function automatic int rs();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dact = MAX_D; m_primed = 0; m_cfg = 0; last_stb = 0;
    h0.delete(); h1.delete(); flen.delete(); exp_q.delete();
  endtask

  // Frame output = input history convolved with N cascaded length-d boxcars
  // (lag N samples), exact once the last N+1 frames all used ratio d.
  task automatic record_frame();
    exp_t   e;
    int     d, n, len, sh;
    bit     steady;
    longint hh[HL];
    longint tmp[HL];
    longint y0, y1;
    d = m_dact;
    flen.push_back(d);
    steady = 1;
    for (int k = 0; k < N + 1 && k < flen.size(); k++)
      if (flen[flen.size() - 1 - k] != d) steady = 0;
    for (int i = 0; i < HL; i++) hh[i] = 0;
    hh[0] = 1; len = 1;
    for (int st = 0; st < N; st++) begin
      for (int i = 0; i < HL; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < d; j++) tmp[i + j] += hh[i];
      hh = tmp;
      len += d - 1;
    end
    n = h0.size() - 1;
    y0 = 0; y1 = 0;
    for (int j = 0; j < len; j++) begin
      if (n - N - j >= 0) begin
        y0 += hh[j] * h0[n - N - j];
        y1 += hh[j] * h1[n - N - j];
      end
    end
    sh = N * lg2(d) - (OW - IW);
    if (sh < 0) sh = 0;
    e.due = cyc + 1 + N;
    e.chk = steady;
    e.e_t = {8'(y1 >>> sh), 8'(y0 >>> sh)};
    e.e_r = {rnd(y1, sh), rnd(y0, sh)};
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input int s0, input int s1, input int dv);
    bit prime, stb;
    prime = !m_primed;
    stb   = 0;
    if (v) begin
      h0.push_back(s0);
      h1.push_back(s1);
      m_primed = 1;
      if (m_cnt == m_dact - 1) begin stb = 1; m_cnt = 0; end
      else m_cnt++;
    end
    if (stb) record_frame();
    if (prime || stb) begin
      if (dv >= 2 && dv <= MAX_D && (dv & (dv - 1)) == 0) m_dact = dv;
      else m_cfg = 1;
    end
    last_stb = stb;
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input int dv);
    @(negedge clk);
    check("d_active", da_t, m_dact);
    check("d_active_rnd", da_r, m_dact);
    check("cfg_err", cfg_t, m_cfg);
    check("cfg_err_rnd", cfg_r, m_cfg);
    in_valid = v;
    d_in     = {8'(s1), 8'(s0)};
    D        = 5'(dv);
    step(v, s0, s1, dv);
  endtask

  task automatic check_reset_state();
    check("rst_d_out", d_out_t, 0);
    check("rst_d_out_rnd", d_out_r, 0);
    check("rst_out_valid", {ov_t, ov_r}, 0);
    check("rst_cfg_err", {cfg_t, cfg_r}, 0);
  endtask

  task automatic do_reset(input int dv);
    in_valid = 0;
    D = 5'(dv);
    rst = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state();
    check("rst_d_active", da_t, MAX_D);
    rst = 1;
    step(0, 0, 0, dv);
  endtask

  task automatic reset_mid(input int dcur, input int dnew);
    int guard = 0;
    do begin
      drive(1, rs(), rs(), dcur);
      guard++;
    end while (!last_stb && guard < 64);
    check("strobe_before_reset", last_stb, 1);
    drive(1, rs(), rs(), dcur);
    drive(1, rs(), rs(), dcur);
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    #1 check_reset_state();
    in_valid = 0;
    D = 5'(dnew);
    repeat (3) @(negedge clk);
    rst = 1;
    step(0, 0, 0, dnew);
  endtask

  // Scoreboard monitor: each expected frame must appear exactly at its due cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("out_valid", ov_t, 1);
      check("out_valid_rnd", ov_r, 1);
      if (e.chk) begin
        check("d_out_lane0", $signed(d_out_t[7:0]), $signed(e.e_t[7:0]));
        check("d_out_lane1", $signed(d_out_t[15:8]), $signed(e.e_t[15:8]));
        check("d_out_rnd_lane0", $signed(d_out_r[7:0]), $signed(e.e_r[7:0]));
        check("d_out_rnd_lane1", $signed(d_out_r[15:8]), $signed(e.e_r[15:8]));
      end
    end else if (ov_t || ov_r) begin
      check("spurious_out_valid", {ov_t, ov_r}, 0);
    end
  end

  initial begin
    int dsel;
    do_reset(8);

    repeat (8 * 8) drive(1, 10, -7, 8);

    repeat (16 * 7) drive(1, -128, -128, 16);
    repeat (16 * 7) drive(1, 127, 127, 16);

    for (int i = 0; i < 8 * 8 * 3; i++) drive(i % 3 == 0, 10, -7, 8);

    repeat (37) drive(1, rs(), rs(), 8);
    repeat (48) drive(1, rs(), rs(), 4);
    repeat (40) drive(1, 10, -7, 4);

    repeat (24) drive(1, rs(), rs(), 8);
    repeat (20) drive(1, rs(), rs(), 3);
    repeat (10) drive(1, rs(), rs(), 20);
    repeat (6)  drive(1, rs(), rs(), 1);
    repeat (6)  drive(1, rs(), rs(), 0);
    repeat (60) drive(1, rs(), rs(), 8);

    reset_mid(8, 4);
    repeat (200) drive($urandom_range(3) != 0, rs(), rs(), 4);

    dsel = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i % 120 == 119) dsel = 2 << $urandom_range(3);
      drive($urandom_range(3) != 0, rs(), rs(), dsel);
    end

    repeat (N + 4) drive(0, 0, 0, dsel);
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
